// File: rtl/bfm_ahb_pkg.sv
// Shared AHB-Lite encodings and the slave memory FSM state type.
package bfm_ahb_pkg;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic [2:0] HsizeByte = 3'd0;
    localparam logic [2:0] HsizeHalf = 3'd1;
    localparam logic [2:0] HsizeWord = 3'd2;

    localparam logic HrespOkay  = 1'b0;
    localparam logic HrespError = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } ahb_state_e;

endpackage

// File: rtl/bfm_ahbslave_lanes.sv
// Little-endian byte-enable decode and write-data merge for one 32-bit RAM word.
module bfm_ahbslave_lanes
    import bfm_ahb_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] new_word_o
);

    always_comb begin
        byte_en_o = 4'b0000;
        case (size_i)
            HsizeByte: byte_en_o = 4'b0001 << addr_lo_i;
            HsizeHalf: byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            HsizeWord: byte_en_o = 4'b1111;
            default:   byte_en_o = 4'b0000;
        endcase
    end

    always_comb begin
        new_word_o = old_word_i;
        for (int i = 0; i < 4; i++) begin
            if (byte_en_o[i]) begin
                new_word_o[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/bfm_ahbslave_mem.sv
// AHB-Lite slave memory model: word RAM, programmable wait states, two-cycle ERROR response.
// Build option: define BFM_AHBSLAVE_RANDWAIT_EN for LFSR-driven random wait counts.
module bfm_ahbslave_mem
    import bfm_ahb_pkg::*;
#(
    parameter int unsigned AWIDTH      = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          CHECK_RANGE = 1'b1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned Depth = 1 << AWIDTH;

    logic [31:0]       mem_q [Depth];
    ahb_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AWIDTH-1:0] word_q, word_d;
    logic [1:0]        lo_q, lo_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;

    logic              accept, can_take, take, addr_err;
    logic [3:0]        wait_cnt;
    logic [31:0]       rd_word, merged_word;
    logic [3:0]        byte_en;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign accept   = HSEL && HREADYIN && HTRANS[1];
    // Only states that end with HREADYOUT=1 can overlap a new address phase.
    assign can_take = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    assign take     = accept && can_take;
    assign rd_word  = mem_q[word_q];

    always_comb begin
        addr_err = 1'b0;
        case (HSIZE)
            HsizeByte: addr_err = 1'b0;
            HsizeHalf: addr_err = HADDR[0];
            HsizeWord: addr_err = |HADDR[1:0];
            default:   addr_err = 1'b1;
        endcase
        if (CHECK_RANGE && ((HADDR >> (AWIDTH + 2)) != 32'd0)) begin
            addr_err = 1'b1;
        end
    end

`ifdef BFM_AHBSLAVE_RANDWAIT_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci form, taps 8,6,5,4.
    always_comb begin
        lfsr_d = lfsr_q;
        if (take) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign wait_cnt = 4'({28'd0, lfsr_q[3:0]} % (WAIT_STATES + 32'd1));
`else
    assign wait_cnt = 4'(WAIT_STATES);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        lo_d    = lo_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1: state_d = StErr2;
            default: begin
                if (take) begin
                    word_d  = HADDR[AWIDTH+1:2];
                    lo_d    = HADDR[1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (addr_err) begin
                        state_d = StErr1;
                    end else if (wait_cnt == 4'd0) begin
                        state_d = StData;
                    end else begin
                        state_d = StWait;
                        cnt_d   = wait_cnt - 4'd1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            word_q  <= '0;
            lo_q    <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            lo_q    <= lo_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    bfm_ahbslave_lanes u_lanes (
        .size_i     (size_q),
        .addr_lo_i  (lo_q),
        .old_word_i (rd_word),
        .wdata_i    (HWDATA),
        .byte_en_o  (byte_en),
        .new_word_o (merged_word)
    );

    // RAM is deliberately not reset; state_q resets asynchronously so no write can fire.
    always_ff @(posedge HCLK) begin
        if (state_q == StData && write_q && |byte_en) begin
            mem_q[word_q] <= merged_word;
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HrespOkay;
        HRDATA    = '0;
        case (state_q)
            StWait: HREADYOUT = 1'b0;
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = HrespError;
            end
            StErr2: HRESP = HrespError;
            StData: begin
                if (!write_q) begin
                    HRDATA = rd_word;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bfm_ahbslave_mem.sv
// Random + directed bench: a pipelined AHB master drives two slaves (0 and 3 wait states)
// and checks every data phase against a byte-level memory model.
module tb_bfm_ahbslave_mem;
    import bfm_ahb_pkg::*;

    localparam int unsigned Ws0 = 0;
    localparam int unsigned Ws3 = 3;

    typedef struct {
        bit          en;
        bit          slv;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [31:0] wdata;
        bit          has_fix;
        logic [31:0] fix;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel3, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        ro0, ro3, resp0, resp3;
    logic [31:0] rd0, rd3;
    logic        sel_dp;
    logic        hready, hresp;
    logic [31:0] hrdata;

    int          n_vec = 0;
    int          n_err = 0;
    xfer_t       q[$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    assign hready = sel_dp ? ro3 : ro0;
    assign hresp  = sel_dp ? resp3 : resp0;
    assign hrdata = sel_dp ? rd3 : rd0;

    always @(posedge clk or posedge rst) begin
        if (rst) sel_dp <= 1'b0;
        else if (hready) sel_dp <= hsel3;
    end

    bfm_ahbslave_mem #(.WAIT_STATES(Ws0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADYIN(hready), .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0)
    );

    bfm_ahbslave_mem #(.WAIT_STATES(Ws3)) u_dut3 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADYIN(hready), .HREADYOUT(ro3), .HRESP(resp3), .HRDATA(rd3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b1;
        if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
        if (a >= 32'd4096) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int mkey(input bit slv, input logic [31:0] a);
        return (slv ? 4096 : 0) + int'(a[11:2]);
    endfunction

    function automatic void mdl_write(input bit slv, input logic [31:0] a, input logic [2:0] s,
                                      input logic [31:0] wd);
        int          key = mkey(slv, a);
        logic [31:0] w   = model.exists(key) ? model[key] : 32'h0;
        for (int b = 0; b < (1 << s); b++) begin
            int lane = int'(a[1:0]) + b;
            w[8*lane +: 8] = wd[8*lane +: 8];
        end
        model[key] = w;
    endfunction

    function automatic void add(input bit en, input bit slv, input bit wr, input logic [31:0] a,
                                input logic [2:0] s, input logic [1:0] t, input logic [31:0] wd,
                                input bit has_fix = 1'b0, input logic [31:0] fix = 32'h0);
        xfer_t x;
        x.en = en; x.slv = slv; x.wr = wr; x.addr = a; x.size = s; x.trans = t;
        x.wdata = wd; x.has_fix = has_fix; x.fix = fix;
        q.push_back(x);
    endfunction

    task automatic drive(input xfer_t x);
        hsel0  = x.en && !x.slv;
        hsel3  = x.en && x.slv;
        haddr  = x.addr;
        htrans = x.trans;
        hwrite = x.wr;
        hsize  = x.size;
    endtask

    task automatic drive_idle();
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = HtransIdle; hwrite = 1'b0;
        haddr = 32'h0; hsize = HsizeWord;
    endtask

    task automatic complete(input xfer_t x, input int waits);
        bit e   = is_err(x.addr, x.size);
        int key = mkey(x.slv, x.addr);
        check_eq("waits", 32'(waits), e ? 32'd1 : (x.slv ? 32'(Ws3) : 32'(Ws0)));
        check_eq("resp", 32'(hresp), 32'(e));
        if (e) begin
            check_eq("err_rdata", hrdata, 32'h0);
        end else if (x.wr) begin
            mdl_write(x.slv, x.addr, x.size, x.wdata);
        end else begin
            if (model.exists(key)) check_eq("rdata", hrdata, model[key]);
            if (x.has_fix) check_eq("rdata_fix", hrdata, x.fix);
        end
    endtask

    // Pipelined master: address phase of item i overlaps data phase of item i-1.
    task automatic run_q();
        int ai    = 0;
        int di    = -1;
        int waits = 0;
        while (ai < q.size() || di >= 0) begin
            @(negedge clk);
            if (di >= 0) hwdata = q[di].wdata;
            if (di >= 0 && !hready) begin
                waits++;
                check_eq("wait_resp", 32'(hresp), 32'(is_err(q[di].addr, q[di].size)));
                if (waits > 20) begin
                    check_eq("wait_bound", 32'(waits), 32'd20);
                    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                    $fatal(1, "wait bound expired");
                end
                continue;
            end
            if (di >= 0) begin
                complete(q[di], waits);
            end else begin
                check_eq("idle_ready", 32'(hready), 32'd1);
                check_eq("idle_resp", 32'(hresp), 32'd0);
            end
            waits = 0;
            if (ai < q.size()) begin
                drive(q[ai]);
                di = (q[ai].en && q[ai].trans[1]) ? ai : -1;
                ai++;
            end else begin
                drive_idle();
                di = -1;
            end
        end
        q.delete();
    endtask

    initial begin
        rst    = 1'b1;
        hwdata = 32'h0;
        drive_idle();
        repeat (2) @(negedge clk);
        check_eq("rst_ready0", 32'(ro0), 32'd1);
        check_eq("rst_ready3", 32'(ro3), 32'd1);
        check_eq("rst_resp0", 32'(resp0), 32'd0);
        check_eq("rst_resp3", 32'(resp3), 32'd0);
        check_eq("rst_rdata0", rd0, 32'h0);
        check_eq("rst_rdata3", rd3, 32'h0);
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                add(1'b1, s[0], 1'b1, 32'(w * 4), HsizeWord, HtransNonseq, $urandom);
            end
        end
        run_q();

        add(1'b1, 1'b0, 1'b1, 32'h10, HsizeWord, HtransNonseq, 32'hDEADBEEF);
        add(1'b1, 1'b0, 1'b0, 32'h10, HsizeWord, HtransNonseq, 32'h0, 1'b1, 32'hDEADBEEF);
        add(1'b1, 1'b1, 1'b1, 32'h10, HsizeWord, HtransNonseq, 32'h12345678);
        add(1'b1, 1'b1, 1'b0, 32'h10, HsizeWord, HtransNonseq, 32'h0, 1'b1, 32'h12345678);
        add(1'b1, 1'b1, 1'b0, 32'h10, HsizeWord, HtransSeq, 32'h0, 1'b1, 32'h12345678);
        add(1'b1, 1'b0, 1'b1, 32'h10, HsizeWord, HtransNonseq, 32'h11223344);
        add(1'b1, 1'b0, 1'b1, 32'h13, HsizeByte, HtransNonseq, 32'h55555555);
        add(1'b1, 1'b0, 1'b0, 32'h10, HsizeWord, HtransNonseq, 32'h0, 1'b1, 32'h55223344);
        add(1'b1, 1'b0, 1'b1, 32'h12, HsizeHalf, HtransNonseq, 32'hAAAAAAAA);
        add(1'b1, 1'b0, 1'b0, 32'h10, HsizeWord, HtransNonseq, 32'h0, 1'b1, 32'hAAAA3344);
        add(1'b1, 1'b0, 1'b1, 32'h02, HsizeWord, HtransNonseq, 32'hFFFFFFFF);
        add(1'b1, 1'b0, 1'b1, 32'h11, HsizeHalf, HtransNonseq, 32'hFFFFFFFF);
        add(1'b1, 1'b0, 1'b1, 32'h10, 3'd3, HtransNonseq, 32'hFFFFFFFF);
        add(1'b1, 1'b1, 1'b1, 32'h1000, HsizeWord, HtransNonseq, 32'hFFFFFFFF);
        add(1'b1, 1'b0, 1'b0, 32'h10, HsizeWord, HtransNonseq, 32'h0, 1'b1, 32'hAAAA3344);
        add(1'b1, 1'b0, 1'b0, 32'h00, HsizeWord, HtransNonseq, 32'h0);
        add(1'b1, 1'b1, 1'b0, 32'h00, HsizeWord, HtransNonseq, 32'h0);
        add(1'b1, 1'b0, 1'b1, 32'h10, HsizeWord, HtransBusy, 32'h0BAD0BAD);
        add(1'b0, 1'b0, 1'b1, 32'h10, HsizeWord, HtransNonseq, 32'h0BAD0BAD);
        add(1'b1, 1'b1, 1'b1, 32'h10, HsizeWord, HtransIdle, 32'h0BAD0BAD);
        add(1'b1, 1'b0, 1'b0, 32'h10, HsizeWord, HtransNonseq, 32'h0, 1'b1, 32'hAAAA3344);
        run_q();

        for (int i = 0; i < 300; i++) begin
            int          r    = int'($urandom_range(0, 99));
            bit          en   = r >= 8;
            logic [1:0]  t    = (r < 18) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            logic [2:0]  s    = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            logic [31:0] a    = ($urandom_range(0, 19) == 0) ? 32'h1000 + 32'($urandom_range(0, 63))
                                                             : 32'($urandom_range(0, 63));
            add(en, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, s, t, $urandom);
        end
        run_q();

        // Reset in the middle of a waited write: the write must be dropped.
        @(negedge clk);
        hsel3 = 1'b1; haddr = 32'h20; htrans = HtransNonseq; hwrite = 1'b1; hsize = HsizeWord;
        @(negedge clk);
        drive_idle();
        hwdata = 32'hFFFF0000;
        check_eq("pre_rst_wait", 32'(hready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ready3", 32'(ro3), 32'd1);
        check_eq("mid_rst_resp3", 32'(resp3), 32'd0);
        check_eq("mid_rst_rdata3", rd3, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        add(1'b1, 1'b1, 1'b0, 32'h20, HsizeWord, HtransNonseq, 32'h0);
        add(1'b1, 1'b0, 1'b0, 32'h10, HsizeWord, HtransNonseq, 32'h0);
        run_q();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
